alu_sequencer: RTL

Multi-cycle issue stage directly upstream of the 8-bit ALU. It accepts one instruction byte and its operand bytes over valid/ready streams, and drives the ALU's `register1`, `register2`, `alu_op` and `out` inputs. It captures the registered ALU result one cycle later, computes status flags, and presents result plus flags on a write-back stream. One instruction is in flight at a time; there is no pipelining across instructions.

---
 rtl/control_pkg.sv | 45 ++++
 rtl/alu_sequencer_flags.sv | 39 +++
 rtl/alu_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared control definitions: the ALU opcode set plus the issue-stage
// state encoding, flag bit positions and opcode classification helpers.
package control;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    SHL = 4'd4,
    SHR = 4'd5,
    ROL = 4'd6,
    ROR = 4'd7,
    AND = 4'd8,
    OR  = 4'd9,
    XOR = 4'd10,
    NOT = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    OPA,
    OPB,
    EXEC,
    CAPT,
    WB
  } seq_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_E = 3;

  // Faulting operations report a zero result with the error bit set.
  localparam logic [3:0] FAULT_FLAGS = (4'b0001 << FLAG_E) | (4'b0001 << FLAG_Z);

  function automatic logic is_unary(alu_op_e op);
    return op inside {SHL, SHR, ROL, ROR, NOT};
  endfunction

  function automatic logic is_legal(logic [3:0] code);
    return code <= 4'd11;
  endfunction

endpackage

// File: rtl/alu_sequencer_flags.sv
// Combinational status-flag generator for one ALU operation, derived from
// the operands and the result rather than from ALU internals.
module alu_flags
  import control::*;
(
  input  alu_op_e     op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  result,
  output logic [3:0]  flags
);

  logic [8:0]  sum9;
  logic [15:0] prod;
  logic        carry;
  logic        error;

  always_comb begin
    sum9  = {1'b0, a} + {1'b0, b};
    prod  = {8'h00, a} * {8'h00, b};
    carry = 1'b0;
    error = 1'b0;
    case (op)
      ADD:      carry = sum9[8];
      SUB:      carry = (a < b);
      MUL:      carry = |prod[15:8];
      DIV:      error = (b == 8'h00);
      SHL, ROL: carry = a[7];
      SHR, ROR: carry = a[0];
      default:  carry = 1'b0;
    endcase
    flags         = 4'b0000;
    flags[FLAG_Z] = (result == 8'h00);
    flags[FLAG_N] = result[7];
    flags[FLAG_C] = carry;
    flags[FLAG_E] = error;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue stage in front of the 8-bit ALU: gathers an opcode and
// its operands, runs one ALU operation, and offers result plus flags for write-back.
module alu_sequencer
  import control::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [7:0]  instr,
  output logic        instr_ready,
  input  logic        opnd_valid,
  input  logic [7:0]  opnd_data,
  output logic        opnd_ready,
  output logic [7:0]  register1,
  output logic [7:0]  register2,
  output alu_op_e     alu_op,
  output logic        alu_out,
  input  logic [7:0]  alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [7:0]  wb_data,
  output logic [3:0]  wb_flags
);

  seq_state_e state;
  logic [3:0] opcode;
  alu_op_e    op_e;
  logic [3:0] flags;
  logic       unused_instr_hi;

  assign op_e            = alu_op_e'(opcode);
  assign unused_instr_hi = ^instr[7:4];

  alu_flags u_flags (
    .op     (op_e),
    .a      (register1),
    .b      (register2),
    .result (alu_result),
    .flags  (flags)
  );

  // Ready/valid and ALU controls are registered alongside the state so every
  // output changes only on a clock edge (or immediately on reset).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opcode      <= 4'h0;
      instr_ready <= 1'b0;
      opnd_ready  <= 1'b0;
      register1   <= 8'h00;
      register2   <= 8'h00;
      alu_op      <= ADD;
      alu_out     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_data     <= 8'h00;
      wb_flags    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_ready && instr_valid) begin
            opcode      <= instr[3:0];
            instr_ready <= 1'b0;
            opnd_ready  <= 1'b1;
            state       <= OPA;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        OPA: begin
          if (opnd_valid) begin
            register1 <= opnd_data;
            if (!is_legal(opcode)) begin
              opnd_ready <= 1'b0;
              wb_data    <= 8'h00;
              wb_flags   <= FAULT_FLAGS;
              wb_valid   <= 1'b1;
              state      <= WB;
            end else if (is_unary(op_e)) begin
              register2  <= 8'h00;
              opnd_ready <= 1'b0;
              alu_op     <= op_e;
              state      <= EXEC;
            end else begin
              state <= OPB;
            end
          end
        end
        OPB: begin
          if (opnd_valid) begin
            register2  <= opnd_data;
            opnd_ready <= 1'b0;
            // Division by zero never reaches the ALU.
            if (op_e == DIV && opnd_data == 8'h00) begin
              wb_data  <= 8'h00;
              wb_flags <= FAULT_FLAGS;
              wb_valid <= 1'b1;
              state    <= WB;
            end else begin
              alu_op <= op_e;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          alu_out <= 1'b1;
          state   <= CAPT;
        end
        CAPT: begin
          alu_out  <= 1'b0;
          alu_op   <= ADD;
          wb_data  <= alu_result;
          wb_flags <= flags;
          wb_valid <= 1'b1;
          state    <= WB;
        end
        WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
